stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Sequencing controller for a two-stage BCD mod-60 counter chain (seconds, minutes) forming an MM:SS stopwatch.
//  Accepts start/stop, lap and clear button pulses plus a count-rate tick; drives run/pause/lap state and
//  a lap-freezable display path. Sits between the button debouncers / prescaler and the 7-seg display driver.
// PARAMETERS
//  WRAP      1  1: 59:59 + tick wraps to 00:00 and keeps running; 0: saturate at 59:59 and force PAUSE
//  TICK_DIV  1  number of tick pulses per count step (1..255); internal 8-bit divider
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  asynchronous, active-low reset
//  tick        in   1  single-cycle count-rate strobe
//  start_stop  in   1  single-cycle pulse, toggles run/pause
//  lap         in   1  single-cycle pulse, freeze/release display
//  clear       in   1  single-cycle pulse, return to IDLE and zero counts
//  sec_bcd     out  8  displayed seconds, [7:4] tens 0-5, [3:0] units 0-9
//  min_bcd     out  8  displayed minutes, same encoding
//  running     out  1  high in RUN and LAP
//  frozen      out  1  high in LAP (display shows snapshot)
//  overflow    out  1  sticky, set on 59:59 rollover/saturation, cleared by clear or reset
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, live counts 00:00, snapshot 00:00, divider 0, all outputs 0.
//  - FSM states IDLE, RUN, PAUSE, LAP. Event priority per cycle: clear > start_stop > lap.
//    IDLE : start_stop -> RUN; lap ignored.
//    RUN  : start_stop -> PAUSE; lap -> LAP (snapshot <= live count value before this edge's increment).
//    LAP  : lap -> RUN (display released); start_stop -> PAUSE (display released, shows live).
//    PAUSE: start_stop -> RUN; lap ignored.
//    any  : clear -> IDLE, live and snapshot = 00:00, divider = 0, overflow = 0.
//  - Counting only in RUN and LAP. Divider increments on tick; when it reaches TICK_DIV-1 with tick high
//    it returns to 0 and issues one step. Divider frozen in IDLE/PAUSE; not reset by pause.
//  - Step: sec units 9->0 carries to sec tens; sec tens 5 with units 9 -> 00 and carries to minutes;
//    minutes identical mod-60. Carry is combinational within the chain: 00:59 -> 01:00 in one edge.
//  - 59:59 + step: WRAP=1 -> 00:00, overflow<=1, state unchanged. WRAP=0 -> hold 59:59, overflow<=1, state->PAUSE;
//    subsequent start_stop -> RUN but steps are ignored while count is 59:59 and WRAP=0.
//  - Same-edge events: start_stop with a step in RUN: the step is applied, then PAUSE. start_stop with
//    step in PAUSE: no step (counting begins next step). clear with step: clear wins, counts 00:00.
//  - Display: sec_bcd/min_bcd = snapshot in LAP, else live count. All outputs registered; a step at edge N
//    is visible on sec_bcd immediately after edge N (latency 1 cycle from tick).
//  - Count values never leave legal BCD; illegal states are unreachable and need no recovery.
// STRUCTURE
//  - Package stopwatch_pkg: state enum {IDLE,RUN,PAUSE,LAP}, BCD constants UNITS_MAX=4'd9, TENS_MAX=4'd5,
//    BCD_59=8'h59.
//  - Sub-module bcd_mod60_cnt (clk, reset, en, clr, q[7:0], co): mod-60 BCD stage, async active-low reset,
//    clr synchronous and dominant over en, co = en & (q==8'h59). Instantiated twice (sec, min), sec.co -> min.en.
//  - Top holds FSM, tick divider, snapshot registers, overflow flag, display mux.
// TESTING
//  1. Reset, start_stop, 75 ticks (TICK_DIV=1) -> min_bcd=8'h01, sec_bcd=8'h15, running=1.
//  2. RUN at 00:42, lap -> frozen=1, display holds 00:42 over 10 ticks; lap -> display 00:52, frozen=0.
//  3. Preload to 59:58 in RUN, 2 ticks: WRAP=1 -> 00:00, overflow=1, running=1; WRAP=0 -> 59:59, state PAUSE.
//  4. Same cycle clear+tick+start_stop at 12:34 -> 00:00, IDLE, overflow=0, running=0.
//  5. TICK_DIV=4: start, 11 ticks, pause, 1 tick, resume, 1 tick -> sec_bcd=8'h03 (divider persists over pause).
//  6. Assert reset mid-RUN between clk edges -> all outputs 0 without waiting for clk; release, start -> counts from 00:00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_pkg : state encoding, BCD limits and the mod-60 BCD increment
// Revision      : 1.0
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [7:0] BCD_59    = 8'h59;

    function automatic logic [7:0] bcd_mod60_inc(input logic [7:0] q);
        logic [7:0] r;
        r = q;
        if (q[3:0] == UNITS_MAX) begin
            r[3:0] = 4'd0;
            r[7:4] = (q[7:4] == TENS_MAX) ? 4'd0 : q[7:4] + 4'd1;
        end else begin
            r[3:0] = q[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if : button/tick inputs and display/status outputs
// Revision          : 1.0
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       running;
    logic       frozen;
    logic       overflow;

    modport master (
        output tick, start_stop, lap, clear,
        input  sec_bcd, min_bcd, running, frozen, overflow
    );

    modport slave (
        input  tick, start_stop, lap, clear,
        output sec_bcd, min_bcd, running, frozen, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_mod60_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_mod60_cnt : one BCD 00..59 counter stage with carry-out
// Revision      : 1.0
// ---------------------------------------------------------------------------
module bcd_mod60_cnt
    import stopwatch_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       en,
    input  wire logic       clr,
    output logic      [7:0] q,
    output logic            co
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 8'h00;
        end else if (clr) begin
            q <= 8'h00;
        end else if (en) begin
            q <= bcd_mod60_inc(q);
        end
    end

    assign co = en & (q == BCD_59);

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_ctrl : MM:SS stopwatch sequencer with lap freeze and overflow flag
// Revision       : 1.0
// ---------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit WRAP     = 1'b1,
    parameter int TICK_DIV = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    stopwatch_ctrl_if.slave bus
);

    localparam logic [7:0] c_div_last = 8'(TICK_DIV - 1);

    sw_state_t  r_state;
    sw_state_t  w_state_next;
    logic [7:0] r_div;
    logic [7:0] w_div_next;
    logic [7:0] w_sec;
    logic [7:0] w_min;
    logic       w_sec_co;
    logic       w_min_co;
    logic [7:0] r_snap_sec;
    logic [7:0] r_snap_min;
    logic [7:0] r_sec_disp;
    logic [7:0] r_min_disp;
    logic       r_running;
    logic       r_frozen;
    logic       r_overflow;

    logic       w_counting;
    logic       w_step;
    logic       w_at_max;
    logic       w_hold;
    logic       w_cnt_en;
    logic       w_force_pause;
    logic       w_ovf_set;
    logic       w_snap_take;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic [7:0] w_snap_sec_next;
    logic [7:0] w_snap_min_next;

    assign w_counting = (r_state == RUN) || (r_state == LAP);
    assign w_step     = w_counting & bus.tick & (r_div == c_div_last);
    assign w_at_max   = (w_sec == BCD_59) && (w_min == BCD_59);
    // Saturating build: once at 59:59 the chain never advances again until clear.
    assign w_hold        = (WRAP == 1'b0) && w_at_max;
    assign w_cnt_en      = w_step & ~w_hold;
    assign w_force_pause = w_step & w_hold & ~r_overflow;
    assign w_ovf_set     = w_min_co | (w_step & w_hold);

    bcd_mod60_cnt u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en),
        .clr   (bus.clear),
        .q     (w_sec),
        .co    (w_sec_co)
    );

    bcd_mod60_cnt u_min (
        .clk   (clk),
        .reset (reset),
        .en    (w_sec_co),
        .clr   (bus.clear),
        .q     (w_min),
        .co    (w_min_co)
    );

    always_comb begin
        w_div_next = r_div;
        if (bus.clear) begin
            w_div_next = 8'd0;
        end else if (w_counting && bus.tick) begin
            w_div_next = (r_div == c_div_last) ? 8'd0 : r_div + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_snap_take  = 1'b0;
        if (bus.clear) begin
            w_state_next = IDLE;
        end else if (bus.start_stop) begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                PAUSE:   w_state_next = RUN;
                LAP:     w_state_next = PAUSE;
                default: w_state_next = IDLE;
            endcase
        end else if (w_force_pause) begin
            w_state_next = PAUSE;
        end else if (bus.lap) begin
            if (r_state == RUN) begin
                w_state_next = LAP;
                w_snap_take  = 1'b1;
            end else if (r_state == LAP) begin
                w_state_next = RUN;
            end
        end
    end

    // Next-edge view of live and snapshot values so the display register carries zero extra latency.
    assign w_sec_next      = bus.clear ? 8'h00 : (w_cnt_en ? bcd_mod60_inc(w_sec) : w_sec);
    assign w_min_next      = bus.clear ? 8'h00 : (w_sec_co ? bcd_mod60_inc(w_min) : w_min);
    assign w_snap_sec_next = bus.clear ? 8'h00 : (w_snap_take ? w_sec : r_snap_sec);
    assign w_snap_min_next = bus.clear ? 8'h00 : (w_snap_take ? w_min : r_snap_min);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= 8'd0;
            r_snap_sec <= 8'h00;
            r_snap_min <= 8'h00;
            r_sec_disp <= 8'h00;
            r_min_disp <= 8'h00;
            r_running  <= 1'b0;
            r_frozen   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_div      <= w_div_next;
            r_snap_sec <= w_snap_sec_next;
            r_snap_min <= w_snap_min_next;
            r_sec_disp <= (w_state_next == LAP) ? w_snap_sec_next : w_sec_next;
            r_min_disp <= (w_state_next == LAP) ? w_snap_min_next : w_min_next;
            r_running  <= (w_state_next == RUN) || (w_state_next == LAP);
            r_frozen   <= (w_state_next == LAP);
            r_overflow <= bus.clear ? 1'b0 : (r_overflow | w_ovf_set);
        end
    end

    assign bus.sec_bcd  = r_sec_disp;
    assign bus.min_bcd  = r_min_disp;
    assign bus.running  = r_running;
    assign bus.frozen   = r_frozen;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl : three stopwatch variants against a seconds-count model
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;
    localparam int NDUT    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tick  = 1'b0;
    logic ss    = 1'b0;
    logic lp    = 1'b0;
    logic cl    = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] sec_o [NDUT];
    logic [7:0] min_o [NDUT];
    logic       run_o [NDUT];
    logic       frz_o [NDUT];
    logic       ovf_o [NDUT];

    stopwatch_ctrl_if sw_if [NDUT] ();

    // Variant 0: wrap, step per tick. Variant 1: saturate. Variant 2: wrap, 4 ticks per step.
    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            assign sw_if[g].tick       = tick;
            assign sw_if[g].start_stop = ss;
            assign sw_if[g].lap        = lp;
            assign sw_if[g].clear      = cl;

            stopwatch_ctrl #(
                .WRAP     ((g == 1) ? 1'b0 : 1'b1),
                .TICK_DIV ((g == 2) ? 4 : 1)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (sw_if[g].slave)
            );

            assign sec_o[g] = sw_if[g].sec_bcd;
            assign min_o[g] = sw_if[g].min_bcd;
            assign run_o[g] = sw_if[g].running;
            assign frz_o[g] = sw_if[g].frozen;
            assign ovf_o[g] = sw_if[g].overflow;
        end
    endgenerate

    int p_div  [NDUT] = '{1, 1, 4};
    bit p_wrap [NDUT] = '{1'b1, 1'b0, 1'b1};

    // Model: elapsed time as a plain seconds count 0..3599.
    int m_secs [NDUT];
    int m_snap [NDUT];
    int m_st   [NDUT];
    int m_div  [NDUT];
    bit m_ovf  [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_secs[k] = 0; m_snap[k] = 0; m_st[k] = M_IDLE; m_div[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit t, input bit s, input bit l, input bit c);
        for (int k = 0; k < NDUT; k++) begin
            int  old;
            bit  step;
            bit  forced;
            old    = m_secs[k];
            step   = 1'b0;
            forced = 1'b0;
            if (c) begin
                m_st[k] = M_IDLE; m_secs[k] = 0; m_snap[k] = 0; m_div[k] = 0; m_ovf[k] = 1'b0;
            end else begin
                if ((m_st[k] == M_RUN || m_st[k] == M_LAP) && t) begin
                    if (m_div[k] == p_div[k] - 1) begin
                        m_div[k] = 0;
                        step = 1'b1;
                    end else begin
                        m_div[k]++;
                    end
                end
                if (step) begin
                    if (m_secs[k] == 3599) begin
                        if (p_wrap[k]) m_secs[k] = 0;
                        else if (!m_ovf[k]) forced = 1'b1;
                        m_ovf[k] = 1'b1;
                    end else begin
                        m_secs[k]++;
                    end
                end
                if (s) begin
                    m_st[k] = (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) ? M_RUN : M_PAUSE;
                end else if (forced) begin
                    m_st[k] = M_PAUSE;
                end else if (l) begin
                    if (m_st[k] == M_RUN) begin
                        m_st[k] = M_LAP;
                        m_snap[k] = old;
                    end else if (m_st[k] == M_LAP) begin
                        m_st[k] = M_RUN;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            int shown;
            shown = (m_st[k] == M_LAP) ? m_snap[k] : m_secs[k];
            check_eq($sformatf("d%0d_sec", k), sec_o[k], to_bcd(shown % 60));
            check_eq($sformatf("d%0d_min", k), min_o[k], to_bcd(shown / 60));
            check_eq($sformatf("d%0d_running", k), run_o[k], (m_st[k] == M_RUN || m_st[k] == M_LAP));
            check_eq($sformatf("d%0d_frozen", k), frz_o[k], (m_st[k] == M_LAP));
            check_eq($sformatf("d%0d_overflow", k), ovf_o[k], m_ovf[k]);
        end
    endtask

    task automatic cycle(input bit t, input bit s, input bit l, input bit c);
        @(negedge clk);
        tick = t; ss = s; lp = l; cl = c;
        @(posedge clk);
        model_step(t, s, l, c);
        #1;
        tick = 1'b0; ss = 1'b0; lp = 1'b0; cl = 1'b0;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Basic counting through a minute carry
        cycle(0, 1, 0, 0);
        ticks(75);
        check_eq("t1_min", min_o[0], 8'h01);
        check_eq("t1_sec", sec_o[0], 8'h15);
        check_eq("t1_running", run_o[0], 1'b1);

        // Lap freeze and release
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        ticks(42);
        cycle(0, 0, 1, 0);
        ticks(10);
        check_eq("t2_frozen_sec", sec_o[0], 8'h42);
        check_eq("t2_frozen", frz_o[0], 1'b1);
        cycle(0, 0, 1, 0);
        check_eq("t2_release_sec", sec_o[0], 8'h52);
        check_eq("t2_release_frozen", frz_o[0], 1'b0);

        // 59:59 boundary: wrap vs saturate
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        ticks(3598);
        check_eq("t3_pre_min", min_o[1], 8'h59);
        check_eq("t3_pre_sec", sec_o[1], 8'h58);
        ticks(2);
        check_eq("t3_wrap_sec", sec_o[0], 8'h00);
        check_eq("t3_wrap_min", min_o[0], 8'h00);
        check_eq("t3_wrap_ovf", ovf_o[0], 1'b1);
        check_eq("t3_wrap_running", run_o[0], 1'b1);
        check_eq("t3_sat_sec", sec_o[1], 8'h59);
        check_eq("t3_sat_min", min_o[1], 8'h59);
        check_eq("t3_sat_running", run_o[1], 1'b0);
        cycle(0, 1, 0, 0);
        ticks(3);
        check_eq("t3_sat_hold_sec", sec_o[1], 8'h59);

        // clear beats tick and start_stop on the same edge
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        ticks(754);
        check_eq("t4_pre_min", min_o[0], 8'h12);
        check_eq("t4_pre_sec", sec_o[0], 8'h34);
        cycle(1, 1, 0, 1);
        check_eq("t4_sec", sec_o[0], 8'h00);
        check_eq("t4_running", run_o[0], 1'b0);
        check_eq("t4_ovf", ovf_o[0], 1'b0);

        // Divider survives a pause
        cycle(0, 1, 0, 0);
        ticks(11);
        cycle(0, 1, 0, 0);
        ticks(1);
        cycle(0, 1, 0, 0);
        ticks(1);
        check_eq("t5_div_sec", sec_o[2], 8'h03);

        // Random mix of all events
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 149) == 0));
        end

        // Asynchronous reset mid-run
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        ticks(5);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("t6_d%0d_sec", k), sec_o[k], 8'h00);
            check_eq($sformatf("t6_d%0d_running", k), run_o[k], 1'b0);
        end
        check_all();
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 1, 0, 0);
        ticks(3);
        check_eq("t6_restart_sec", sec_o[0], 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
